// File: rtl/eth_header_parser.sv
// Ethernet II receive-side header parser: captures MACs, ethertype and an optional 802.1Q tag,
// classifies the frame and forwards payload bytes one clock after they arrive.
module eth_header_parser #(
    parameter logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01,
    parameter bit          VLAN_EN = 1'b1,
    parameter bit          PROMISC = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  datain,
    input  logic        data_en,
    output logic [47:0] BOARD_MAC,
    output logic [47:0] PC_MAC,
    output logic [15:0] ethertype,
    output logic [11:0] vlan_id,
    output logic        has_vlan,
    output logic        isIp,
    output logic        isARP,
    output logic        isNotAValidPacket,
    output logic        hdr_done,
    output logic        err_short,
    output logic [7:0]  payload,
    output logic        payload_en
);

    typedef enum logic [2:0] {WAIT, IDLE, MAC, TYPE, VLAN, PAYLOAD, DROP} state_t;

    localparam logic [15:0] ET_IPV4 = 16'h0800;
    localparam logic [15:0] ET_ARP  = 16'h0806;
    localparam logic [15:0] ET_VLAN = 16'h8100;

    state_t      state, state_nxt;
    logic [4:0]  idx, idx_nxt;

    logic [15:0] last_type;
    logic        addr_ok, type_ip, type_arp, frame_ok, tag_seen;
    logic        start_frame, mac_ld, type_ld, vlan_ld, hdr_fin, err_pulse, fwd;

    // The high type byte is already registered when the low one is on datain.
    assign last_type = {ethertype[15:8], datain};
    assign addr_ok   = PROMISC || (BOARD_MAC == MY_MAC) || (BOARD_MAC == 48'hFFFF_FFFF_FFFF);
    assign type_ip   = addr_ok && (last_type == ET_IPV4);
    assign type_arp  = addr_ok && (last_type == ET_ARP);
    assign frame_ok  = type_ip || type_arp;
    assign tag_seen  = VLAN_EN && (state == TYPE) && (last_type == ET_VLAN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= WAIT;
            idx   <= 5'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            WAIT: begin
                if (!data_en) state_nxt = IDLE;
            end
            IDLE: begin
                if (data_en) begin
                    state_nxt = MAC;
                    idx_nxt   = 5'd1;
                end
            end
            MAC: begin
                if (idx == 5'd11) state_nxt = TYPE;
            end
            TYPE: begin
                if (idx == 5'd13) state_nxt = tag_seen ? VLAN : (frame_ok ? PAYLOAD : DROP);
            end
            VLAN: begin
                if (idx == 5'd17) state_nxt = frame_ok ? PAYLOAD : DROP;
            end
            default: ;
        endcase
        // A low data_en ends the frame from any active state; idx saturates at 31.
        if (state != WAIT && state != IDLE) begin
            if (!data_en) begin
                state_nxt = IDLE;
                idx_nxt   = 5'd0;
            end else if (idx != 5'd31) begin
                idx_nxt = idx + 5'd1;
            end
        end
    end

    always_comb begin
        start_frame = (state == IDLE) && data_en;
        mac_ld      = (state == MAC)  && data_en;
        type_ld     = (state == TYPE) && data_en;
        vlan_ld     = (state == VLAN) && data_en;
        hdr_fin     = data_en && (((state == TYPE) && (idx == 5'd13) && !tag_seen) ||
                                  ((state == VLAN) && (idx == 5'd17)));
        err_pulse   = !data_en && ((state == MAC) || (state == TYPE) || (state == VLAN));
        fwd         = (state == PAYLOAD) && data_en;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            BOARD_MAC         <= 48'h0;
            PC_MAC            <= 48'h0;
            ethertype         <= 16'h0;
            vlan_id           <= 12'h0;
            has_vlan          <= 1'b0;
            isIp              <= 1'b0;
            isARP             <= 1'b0;
            isNotAValidPacket <= 1'b0;
            hdr_done          <= 1'b0;
            err_short         <= 1'b0;
            payload           <= 8'h0;
            payload_en        <= 1'b0;
        end else begin
            hdr_done   <= 1'b0;
            err_short  <= err_pulse;
            payload_en <= fwd;
            if (fwd) payload <= datain;

            if (start_frame) begin
                BOARD_MAC[47:40]  <= datain;
                isIp              <= 1'b0;
                isARP             <= 1'b0;
                isNotAValidPacket <= 1'b0;
                has_vlan          <= 1'b0;
                vlan_id           <= 12'h0;
            end

            if (mac_ld) begin
                case (idx)
                    5'd1:  BOARD_MAC[39:32] <= datain;
                    5'd2:  BOARD_MAC[31:24] <= datain;
                    5'd3:  BOARD_MAC[23:16] <= datain;
                    5'd4:  BOARD_MAC[15:8]  <= datain;
                    5'd5:  BOARD_MAC[7:0]   <= datain;
                    5'd6:  PC_MAC[47:40]    <= datain;
                    5'd7:  PC_MAC[39:32]    <= datain;
                    5'd8:  PC_MAC[31:24]    <= datain;
                    5'd9:  PC_MAC[23:16]    <= datain;
                    5'd10: PC_MAC[15:8]     <= datain;
                    5'd11: PC_MAC[7:0]      <= datain;
                    default: ;
                endcase
            end

            if (type_ld) begin
                if (idx == 5'd12) ethertype[15:8] <= datain;
                if (idx == 5'd13) begin
                    ethertype[7:0] <= datain;
                    if (tag_seen) has_vlan <= 1'b1;
                end
            end

            // Inside the tag the TPID-visible ethertype is replaced by the inner type.
            if (vlan_ld) begin
                case (idx)
                    5'd14: vlan_id[11:8]   <= datain[3:0];
                    5'd15: vlan_id[7:0]    <= datain;
                    5'd16: ethertype[15:8] <= datain;
                    5'd17: ethertype[7:0]  <= datain;
                    default: ;
                endcase
            end

            if (hdr_fin) begin
                hdr_done          <= 1'b1;
                isIp              <= type_ip;
                isARP             <= type_arp;
                isNotAValidPacket <= !frame_ok;
            end
        end
    end

    a_flags_exclusive: assert property (@(posedge clock) disable iff (reset)
        $onehot0({isIp, isARP, isNotAValidPacket}));

endmodule

// File: doc/eth_header_parser.md
ETH_HEADER_PARSER -- requirements
Module: eth_header_parser

Interface
REQ-001 SHALL provide parameter MY_MAC, default 48'h02_00_00_00_00_01, the board MAC accepted as destination.
REQ-002 SHALL provide parameter VLAN_EN, default 1, enabling 802.1Q tag parsing.
REQ-003 SHALL provide parameter PROMISC, default 0; when 1, the destination MAC filter is disabled.
REQ-004 SHALL have port clock, input, 1, the single rising-edge clock.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have ports datain (input, 8, frame byte) and data_en (input, 1; high for every byte of a frame, low for at least 1 cycle between frames).
REQ-007 SHALL have outputs BOARD_MAC (48, destination MAC), PC_MAC (48, source MAC), ethertype (16), vlan_id (12) and has_vlan (1).
REQ-008 SHALL have 1-bit outputs isIp, isARP and isNotAValidPacket (classification flags), hdr_done (1-cycle pulse) and err_short (1-cycle pulse).
REQ-009 SHALL have outputs payload (8) and payload_en (1), the forwarded payload stream.

Function
REQ-010 SHALL implement states WAIT, IDLE, MAC, TYPE, VLAN, PAYLOAD and DROP, with a 5-bit byte index that saturates at 31 and never wraps.
REQ-011 WAIT SHALL go to IDLE on the first cycle data_en=0.
REQ-012 IDLE with data_en=1: SHALL clear all flags, has_vlan and vlan_id; SHALL store the byte in BOARD_MAC[47:40]; next state MAC, index=1.
REQ-013 MAC: bytes 0-5 SHALL fill BOARD_MAC and bytes 6-11 SHALL fill PC_MAC, MSB first; byte 11 SHALL go to TYPE.
REQ-014 TYPE: ethertype SHALL be {byte12, byte13}.
REQ-015 If VLAN_EN=1 and the tag equals 16'h8100, SHALL set has_vlan=1 and go to VLAN.
REQ-016 VLAN: vlan_id SHALL be {byte14[3:0], byte15}; ethertype SHALL be overwritten with {byte16, byte17}.
REQ-017 The final type byte is 13, or 17 when tagged; one clock after it is sampled, flags SHALL be valid and hdr_done SHALL pulse for exactly 1 cycle.
REQ-018 Classification: isIp=1 for 16'h0800 and isARP=1 for 16'h0806; any other type SHALL set isNotAValidPacket=1.
REQ-019 Inner type 16'h8100 (double tag), or tag 16'h8100 with VLAN_EN=0, SHALL set isNotAValidPacket=1.
REQ-020 Address filter (PROMISC=0): if BOARD_MAC is neither MY_MAC nor 48'hFFFF_FFFF_FFFF, SHALL set isNotAValidPacket=1 and force isIp=isARP=0.
REQ-021 At most one of isIp, isARP and isNotAValidPacket SHALL be high.
REQ-022 After hdr_done: valid frame -> PAYLOAD; invalid frame -> DROP.
REQ-023 PAYLOAD: each byte with data_en=1 SHALL appear on payload with payload_en=1 exactly 1 clock later; payload_en SHALL be 0 for header bytes and in DROP.
REQ-024 Any state other than WAIT, when data_en=0, SHALL go to IDLE on the next cycle.
REQ-025 If data_en falls in MAC, TYPE or VLAN, SHALL pulse err_short for 1 cycle; SHALL NOT assert hdr_done; flags SHALL stay 0.
REQ-026 MACs, ethertype, vlan_id, has_vlan and flags SHALL hold until the first byte of the next frame.
REQ-027 Back-to-back frames separated by 1 idle cycle SHALL parse without loss.

Reset
REQ-028 While reset=1, all outputs SHALL be 0, the index SHALL be 0 and the state SHALL be WAIT, independent of clock.
REQ-029 After reset deasserts with data_en=1 (mid-frame), the remaining bytes SHALL be ignored until data_en goes low; payload_en and hdr_done SHALL stay 0.

Verification
REQ-030 Untagged frame, dst=MY_MAC, type 08 00, 4 payload bytes AA BB CC DD -> hdr_done pulse; isIp=1; AA..DD on payload with payload_en high 4 cycles, 1-cycle latency.
REQ-031 Tagged frame, dst=FF..FF, 81 00 0F 23 08 06 -> has_vlan=1; vlan_id=12'hF23; ethertype=16'h0806; isARP=1.
REQ-032 dst=02:00:00:00:00:02, type 0800, PROMISC=0 -> isNotAValidPacket=1; payload_en never high; PROMISC=1 rerun -> isIp=1.
REQ-033 data_en drops after byte 9 -> err_short single pulse; no hdr_done; the next frame after a 1-cycle gap parses correctly.
REQ-034 reset asserted mid-payload and released while data_en=1 -> outputs 0 immediately; no payload_en until data_en low then a new frame.
REQ-035 VLAN_EN=0 with tag 8100 -> isNotAValidPacket=1; has_vlan=0.
